// File: rtl/axi_lite_master_if.sv
// Bus bundle for axi_lite_master: command/response port plus the five AXI4-Lite channels.
// The master modport is the initiator's view; the slave modport is the environment's view.
interface axi_lite_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic                  i_cmd_write;
  logic [ADDR_WIDTH-1:0] i_cmd_addr;
  logic [DATA_WIDTH-1:0] i_cmd_wdata;

  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic                  o_rsp_write;
  logic [1:0]            o_rsp_resp;
  logic                  o_rsp_timeout;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;

  logic                  o_awvalid;
  logic                  i_awready;
  logic [ADDR_WIDTH-1:0] o_awaddr;
  logic                  o_wvalid;
  logic                  i_wready;
  logic [DATA_WIDTH-1:0] o_wdata;
  logic                  i_bvalid;
  logic                  o_bready;
  logic [1:0]            i_bresp;
  logic                  o_arvalid;
  logic                  i_arready;
  logic [ADDR_WIDTH-1:0] o_araddr;
  logic                  i_rvalid;
  logic                  o_rready;
  logic [1:0]            i_rresp;
  logic [DATA_WIDTH-1:0] i_rdata;

  modport master (
    input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
    input  i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rresp, i_rdata,
    output o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_timeout, o_rsp_rdata,
    output o_awvalid, o_awaddr, o_wvalid, o_wdata, o_bready, o_arvalid, o_araddr, o_rready
  );

  modport slave (
    output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_rsp_ready,
    output i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rresp, i_rdata,
    input  o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_resp, o_rsp_timeout, o_rsp_rdata,
    input  o_awvalid, o_awaddr, o_wvalid, o_wdata, o_bready, o_arvalid, o_araddr, o_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Command-driven AXI4-Lite initiator: one register access at a time, one response per command,
// with a watchdog that turns a hung slave into a SLVERR-style timeout response.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               i_axi_clk,
  input logic               i_axi_rst,
  axi_lite_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  localparam logic        WDOG_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0]           wdog_q, wdog_d;

  logic [31:0]           wdog_inc;
  logic                  expire;
  logic                  go_timeout;
  logic                  aw_done;
  logic                  w_done;

  // Every output is a register: this block computes the next value of each one.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    araddr_d      = araddr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    wdog_d        = wdog_q;
    wdog_inc      = wdog_q + 32'd1;
    expire        = WDOG_EN && (wdog_inc >= TIMEOUT_LIM);
    go_timeout    = 1'b0;
    aw_done       = !awvalid_q || bus.i_awready;
    w_done        = !wvalid_q || bus.i_wready;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.i_cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          wdog_d      = '0;
          if (bus.i_cmd_write) begin
            awaddr_d  = bus.i_cmd_addr;
            wdata_d   = bus.i_cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = bus.i_cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end

      // AW and W retire independently; B is only opened once both have gone.
      WR_REQ: begin
        wdog_d = wdog_inc;
        if (awvalid_q && bus.i_awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.i_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end else if (expire) begin
          rsp_write_d = 1'b1;
          go_timeout  = 1'b1;
        end
      end

      WR_RESP: begin
        wdog_d = wdog_inc;
        if (bus.i_bvalid && bready_q) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_resp_d    = bus.i_bresp;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = '0;
          state_d       = RSP;
        end else if (expire) begin
          rsp_write_d = 1'b1;
          go_timeout  = 1'b1;
        end
      end

      RD_REQ: begin
        wdog_d = wdog_inc;
        if (arvalid_q && bus.i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else if (expire) begin
          rsp_write_d = 1'b0;
          go_timeout  = 1'b1;
        end
      end

      RD_DATA: begin
        wdog_d = wdog_inc;
        if (bus.i_rvalid && rready_q) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_resp_d    = bus.i_rresp;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = bus.i_rdata;
          state_d       = RSP;
        end else if (expire) begin
          rsp_write_d = 1'b0;
          go_timeout  = 1'b1;
        end
      end

      RSP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Expiry abandons the bus entirely, so late B/R beats find no ready.
    if (go_timeout) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d   = '0;
      state_d       = RSP;
    end
  end

  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      araddr_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      araddr_q      <= araddr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wdog_q        <= wdog_d;
    end
  end

  assign bus.o_cmd_ready   = cmd_ready_q;
  assign bus.o_awvalid     = awvalid_q;
  assign bus.o_awaddr      = awaddr_q;
  assign bus.o_wvalid      = wvalid_q;
  assign bus.o_wdata       = wdata_q;
  assign bus.o_bready      = bready_q;
  assign bus.o_arvalid     = arvalid_q;
  assign bus.o_araddr      = araddr_q;
  assign bus.o_rready      = rready_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_write   = rsp_write_q;
  assign bus.o_rsp_resp    = rsp_resp_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Command-driven AXI4-Lite initiator. Converts single register-access commands (one write or one read at a time) into AXI4-Lite address/data/response handshakes and returns one response per command. It sits on the control side of `dtw_accel`, so a sequencer, test harness or soft controller can program and poll the accelerator's register map without hand-driving AXI channels. A watchdog bounds every transaction, so a hung slave cannot lock up the command port.

## Interface
- `ADDR_WIDTH`, 16: AXI address width; addresses pass through unchanged as byte addresses.
- `DATA_WIDTH`, 32: AXI data width.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles from command accept; 0 disables the watchdog.
- `i_axi_clk` in 1: single clock for all logic.
- `i_axi_rst` in 1: reset, asynchronous assert, active-low.
- `i_cmd_valid` in 1: command present.
- `o_cmd_ready` out 1: command accepted on `i_cmd_valid & o_cmd_ready`.
- `i_cmd_write` in 1: 1 = write, 0 = read.
- `i_cmd_addr` in ADDR_WIDTH: target byte address.
- `i_cmd_wdata` in DATA_WIDTH: write data; ignored for reads.
- `o_rsp_valid` out 1: response present.
- `i_rsp_ready` in 1: response consumed on `o_rsp_valid & i_rsp_ready`.
- `o_rsp_write` out 1: echoes `i_cmd_write` of the completed command.
- `o_rsp_resp` out 2: BRESP or RRESP; 2'b10 on timeout.
- `o_rsp_timeout` out 1: watchdog expired for this command.
- `o_rsp_rdata` out DATA_WIDTH: RDATA for reads; 0 for writes and timeouts.
- `o_awvalid`/`i_awready`/`o_awaddr`: write address channel (1/1/ADDR_WIDTH).
- `o_wvalid`/`i_wready`/`o_wdata`: write data channel (1/1/DATA_WIDTH).
- `i_bvalid`/`o_bready`/`i_bresp`: write response channel (1/1/2).
- `o_arvalid`/`i_arready`/`o_araddr`: read address channel (1/1/ADDR_WIDTH).
- `i_rvalid`/`o_rready`/`i_rresp`/`i_rdata`: read data channel (1/1/2/DATA_WIDTH).

## Operation
- All outputs are registered.
- Reset value of every output is 0, except `o_cmd_ready` = 1 after reset release. The FSM resets to IDLE and the watchdog resets to 0.
- States and transitions:
  - IDLE: `o_cmd_ready` = 1. On accept, latch addr/wdata/write. Go to WR_REQ if write, else RD_REQ.
  - WR_REQ: assert `o_awvalid` and `o_wvalid` together. Each drops independently on its own handshake; handshakes on AW and W may occur in either order or the same cycle. When both have completed, go to WR_RESP.
  - WR_RESP: `o_bready` = 1. On `i_bvalid`, capture BRESP and go to RSP.
  - RD_REQ: `o_arvalid` = 1 until `i_arready`, then go to RD_DATA.
  - RD_DATA: `o_rready` = 1. On `i_rvalid`, capture RDATA/RRESP and go to RSP.
  - RSP: `o_rsp_valid` = 1, with fields stable until `i_rsp_ready`. On handshake, go to IDLE.
- Only one outstanding transaction. No new command is accepted until the response handshake completes.
- Watchdog:
  - It counts every cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
  - When the count reaches `TIMEOUT_CYCLES`, deassert all AXI valids/readies on the next edge and go to RSP with `o_rsp_timeout` = 1, `o_rsp_resp` = 2'b10, `o_rsp_rdata` = 0.
  - If a handshake completes in the same cycle the count expires, the handshake wins.
  - Late B/R beats arriving after a timeout are ignored; `o_bready`/`o_rready` stay 0.
- RSP non-timeout: `o_rsp_timeout` = 0 and `o_rsp_resp` = captured response, passed through verbatim including 2'b10/2'b11.
- Reset mid-transaction: all outputs return to reset values asynchronously; the pending command is dropped and no response is produced.

## Timing
- Cycle 0: command handshake.
- Cycle 1: `o_awvalid`/`o_wvalid` (or `o_arvalid`) high.
- With an always-ready slave:
  - AW/W (or AR) handshake in cycle 1.
  - `o_bready`/`o_rready` high from cycle 2.
  - B/R handshake at cycle N ≥ 2.
  - `o_rsp_valid` high at N+1.
  - `o_cmd_ready` high again the cycle after the response handshake.
- Minimum command-to-response latency: 3 cycles. Minimum command-to-command spacing: 4 cycles.
- A valid never drops before its ready, except on watchdog expiry or reset.
- AXI address/data outputs are held stable while their valid is high.

## Test plan
- Write 0x00000005 to 0x0000, slave always ready, BRESP = 0: AW/W valid in cycle 1, bready in cycle 2; response write = 1, resp = 0, rdata = 0, timeout = 0 at cycle 3.
- Read 0x0010, slave returns 0x0ca7cafe after 4-cycle RVALID delay: `o_arvalid` for 1 cycle; response rdata = 0x0ca7cafe, resp = 0.
- Write with AWREADY delayed 3 cycles and WREADY delayed 1 cycle, then reversed, then both in the same cycle: each valid drops exactly on its own handshake; BREADY rises only after both handshakes; one response each time.
- Hold `i_rsp_ready` = 0 for 5 cycles after a read: response fields stable; `o_cmd_ready` = 0 throughout; next command is accepted only after the handshake.
- `TIMEOUT_CYCLES` = 8, slave never asserts ARREADY: `o_arvalid` drops after 8 cycles; response timeout = 1, resp = 2'b10, rdata = 0. A late RVALID afterwards is ignored. `TIMEOUT_CYCLES` = 0 with the same slave never times out.
- Assert reset during WR_RESP with `i_bvalid` pending: all outputs 0 immediately; `o_cmd_ready` = 1 after release; no spurious `o_rsp_valid`; next read completes normally.
